// File: rtl/idli_uart_tx_m.sv
// 8N1 UART transmitter behind a 2-byte buffer; start bit appears 2 cycles after the accepting edge.
// o_uart_tx_acp drops whenever the request's byte count exceeds the free buffer space.
module idli_uart_tx_m #(
  parameter int CLKS_PER_BIT = 16,
  parameter int BUF_DEPTH    = 2
) (
  input  logic        i_uart_gck,
  input  logic        i_uart_rst_n,
  input  logic        i_uart_tx_vld,
  input  logic        i_uart_tx_lo,
  input  logic        i_uart_tx_hi,
  input  logic [15:0] i_uart_tx_data,
  output logic        o_uart_tx_acp,
  output logic        o_uart_tx_busy,
  output logic        o_uart_tx
);

  localparam int             BCW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]     DEPTH     = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state;
  logic [BCW-1:0] bcnt;
  logic [2:0]     idx;
  logic [7:0]     shift;
  logic           tx_q;

  logic [7:0]     buf_q [2];
  logic           wptr;
  logic           rptr;
  logic [1:0]     occ;

  logic [1:0]     req_n;
  logic [1:0]     free;
  logic           acp;
  logic           push;
  logic           pop;
  logic           bit_end;

  // Free space uses the pre-pop occupancy, so a same-cycle pop never frees room early.
  always_comb begin
    req_n   = {1'b0, i_uart_tx_lo} + {1'b0, i_uart_tx_hi};
    free    = DEPTH - occ;
    acp     = free >= req_n;
    push    = i_uart_tx_vld && acp && (req_n != 2'd0);
    bit_end = (bcnt == BCNT_LAST);
    pop     = (occ != 2'd0) && ((state == IDLE) || ((state == STOP) && bit_end));
  end

  assign o_uart_tx_acp  = acp;
  assign o_uart_tx_busy = (occ != 2'd0) || (state != IDLE);
  assign o_uart_tx      = tx_q;

  // Lo lands in the write slot, hi in the one after it, so lo leaves the line first.
  always_ff @(posedge i_uart_gck) begin
    if (push) begin
      if (i_uart_tx_lo) begin
        buf_q[wptr] <= i_uart_tx_data[7:0];
        if (i_uart_tx_hi) begin
          buf_q[~wptr] <= i_uart_tx_data[15:8];
        end
      end else begin
        buf_q[wptr] <= i_uart_tx_data[15:8];
      end
    end
  end

  always_ff @(posedge i_uart_gck) begin
    if (!i_uart_rst_n) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (push) begin
        wptr <= wptr ^ req_n[0];
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      occ <= occ + (push ? req_n : 2'd0) - {1'b0, pop};
    end
  end

  // tx_q is loaded with the level of the state being entered, keeping the line aligned with state.
  always_ff @(posedge i_uart_gck) begin
    if (!i_uart_rst_n) begin
      state <= IDLE;
      bcnt  <= '0;
      idx   <= 3'd0;
      shift <= 8'h00;
      tx_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= buf_q[rptr];
            bcnt  <= '0;
            state <= START;
            tx_q  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            bcnt  <= '0;
            idx   <= 3'd0;
            state <= DATA;
            tx_q  <= shift[0];
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bcnt <= '0;
            if (idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              idx  <= idx + 3'd1;
              tx_q <= shift[idx + 3'd1];
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bcnt <= '0;
            if (pop) begin
              shift <= buf_q[rptr];
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          bcnt  <= '0;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/idli_uart_tx_m.md
Name: idli_uart_tx_m

Overview:
- UART transmitter at the far end of the core's UART TX interface.
- Accepts `uart_tx_lo` / `uart_tx_hi` byte requests from the core's execute stage and buffers up to two bytes.
- Serialises the buffered bytes as 8N1 frames on the TX line.
- Drives the acceptance signal that the clock-sync block uses to stall the core while the UART cannot take a request.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.
- BUF_DEPTH, 2, byte buffer entries; fixed at 2 so a lo+hi request fits in one acceptance.

Ports:
- i_uart_gck  input  1  clock, rising edge.
- i_uart_rst_n  input  1  reset, synchronous, active-low.
- i_uart_tx_vld  input  1  request valid from execute.
- i_uart_tx_lo  input  1  request includes byte data[7:0].
- i_uart_tx_hi  input  1  request includes byte data[15:8].
- i_uart_tx_data  input  16  operand data for the request.
- o_uart_tx_acp  output  1  request accepted this cycle.
- o_uart_tx_busy  output  1  buffer non-empty or frame in flight.
- o_uart_tx  output  1  serial line, idle high.

Behaviour:
- Reset (synchronous, active-low, sampled on rising edge of i_uart_gck):
  - Buffer empty, occupancy=0, shifter in IDLE, o_uart_tx=1, o_uart_tx_busy=0.
  - o_uart_tx_acp=1 after reset, since it is combinational on registered occupancy.
  - Reset mid-frame aborts the frame: line returns to 1 on the next cycle and buffered bytes are discarded.
- Request size: n = lo + hi (0..2).
- o_uart_tx_acp = (BUF_DEPTH - occupancy) >= n.
  - Depends only on registered occupancy and on lo/hi; never on i_uart_tx_vld.
  - n=0 gives acp=1; a vld request with n=0 is a no-op.
- Push happens when vld && acp && n>0.
  - When both lo and hi are set, lo is enqueued before hi, so lo is transmitted first.
  - Pushes land at the end of the cycle.
- Buffer is a 2-entry circular FIFO with 1-bit read/write pointers.
  - Pointers wrap modulo 2.
  - Occupancy (2 bits) is updated by +pushes -pop in the same cycle; simultaneous push and pop are legal.
  - Free space for acp is computed from occupancy before that cycle's pop, which is conservative.
- Shifter FSM, with baud counter bcnt (0..CLKS_PER_BIT-1) and bit counter idx (0..7):
  - IDLE: o_uart_tx=1. If occupancy>0: pop the head into shift register, set bcnt=0, go to START.
  - START: o_uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with idx=0.
  - DATA: o_uart_tx=shift[idx], LSB first, each bit held CLKS_PER_BIT cycles. After idx=7 completes, go to STOP.
  - STOP: o_uart_tx=1 for CLKS_PER_BIT cycles. On the last cycle: if occupancy>0, pop and go directly to START (no idle gap); else go to IDLE.
- Latency:
  - A push into an empty IDLE block shows the start bit on o_uart_tx 2 cycles after the accepting edge (pop cycle, then START).
  - A frame is exactly 10*CLKS_PER_BIT cycles.
- o_uart_tx is driven from a register and never glitches.
- o_uart_tx_busy = (occupancy != 0) || (state != IDLE).
- Requests arriving while occupancy=2 see acp=0 until the pop at the next frame start.
- Pop and push in the same cycle with occupancy=2 and n=1: acp=0 that cycle, because the pre-pop value is used.
- Behaviour is undefined when vld is low but lo/hi are set; acp still reflects the formula.

Test Plan:
1. Reset then idle, CLKS_PER_BIT=4: o_uart_tx=1, busy=0, acp=1 for 20 cycles.
2. Single lo request, data=0x12A5 -> acp=1. Line: start 0 for 4 cycles, bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) each 4 cycles, stop 1 for 4 cycles. Busy falls after cycle 40 of the frame.
3. lo+hi request, data=0x3C81 -> acp=1. Frame 0x81 then frame 0x3C back-to-back with no idle gap (80 cycles total).
4. Buffer full (lo+hi accepted, first byte popped, one more lo accepted), then a new lo request -> acp=0 until the next pop edge, then acp=1. All three bytes are transmitted in order.
5. Reset asserted at cycle 17 of a frame with one byte queued -> next cycle o_uart_tx=1, busy=0, acp=1, and no further frames are sent.
6. Request with lo=hi=0, vld=1 -> acp=1, no push, line stays idle, busy=0.
